ssd1306_spi_master: RTL

SPI mode-0 master that serializes command and data bytes onto the 4-wire interface of an SSD1306-style display: CS, SCK, MOSI and D/C. It is the transmitting end of the link that the display-replica top receives. It sits between a byte-producing controller (init sequencer or framebuffer streamer) and the FPGA pins. Bytes are taken through a Ready/Start handshake and can be streamed back-to-back under one CS assertion.

---
 rtl/ssd1306_spi_master.sv | 131 +++++++++++++
 1 files changed

// File: rtl/ssd1306_spi_master.sv
// SPI mode-0 master for an SSD1306-style panel: shifts command/data bytes MSB first
// on CS/SCK/MOSI/D-C, with a Ready/Start byte handshake and optional CS hold between bytes.
module ssd1306_spi_master #(
  parameter int HALF_PERIOD_CLKS = 2
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic       Start_i,
  input  logic [7:0] Data_i,
  input  logic       DC_i,
  input  logic       Last_i,
  output logic       Ready_o,
  output logic       Done_o,
  output logic       CS_o,
  output logic       SCK_o,
  output logic       MOSI_o,
  output logic       DC_o
);

  localparam int HW = $clog2(HALF_PERIOD_CLKS) + 1;
  localparam logic [HW-1:0] HLAST = HW'(HALF_PERIOD_CLKS - 1);

  typedef enum logic [2:0] {
    ST_IDLE, ST_SHIFT_LO, ST_SHIFT_HI, ST_WAIT, ST_HOLD, ST_GAP
  } state_t;

  state_t          state_q, state_d;
  logic [HW-1:0]   hcnt_q, hcnt_d;
  logic [2:0]      bit_q, bit_d;
  logic [7:0]      shreg_q, shreg_d;
  logic            last_q, last_d;
  logic            dc_d;
  logic            done_d;
  logic            half_end;

  assign half_end = (hcnt_q == HLAST);

  always_comb begin
    state_d = state_q;
    hcnt_d  = hcnt_q;
    bit_d   = bit_q;
    shreg_d = shreg_q;
    last_d  = last_q;
    dc_d    = DC_o;
    done_d  = 1'b0;
    case (state_q)
      ST_IDLE, ST_WAIT: begin
        // Ready_o is a pure decode of IDLE/WAIT, so this is the accept condition.
        if (Start_i) begin
          shreg_d = Data_i;
          dc_d    = DC_i;
          last_d  = Last_i;
          hcnt_d  = '0;
          bit_d   = '0;
          state_d = ST_SHIFT_LO;
        end
      end
      ST_SHIFT_LO: begin
        if (half_end) begin
          hcnt_d  = '0;
          state_d = ST_SHIFT_HI;
        end else begin
          hcnt_d = hcnt_q + HW'(1);
        end
      end
      ST_SHIFT_HI: begin
        if (half_end) begin
          hcnt_d = '0;
          if (bit_q == 3'd7) begin
            // Keep bit 0 on MOSI while parked between bytes.
            done_d  = 1'b1;
            state_d = last_q ? ST_HOLD : ST_WAIT;
          end else begin
            bit_d   = bit_q + 3'd1;
            shreg_d = {shreg_q[6:0], 1'b0};
            state_d = ST_SHIFT_LO;
          end
        end else begin
          hcnt_d = hcnt_q + HW'(1);
        end
      end
      ST_HOLD, ST_GAP: begin
        if (half_end) begin
          hcnt_d  = '0;
          state_d = (state_q == ST_HOLD) ? ST_GAP : ST_IDLE;
        end else begin
          hcnt_d = hcnt_q + HW'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state_q <= ST_IDLE;
      hcnt_q  <= '0;
      bit_q   <= '0;
      last_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      hcnt_q  <= hcnt_d;
      bit_q   <= bit_d;
      last_q  <= last_d;
    end
  end

  always_ff @(posedge Clock) begin
    shreg_q <= shreg_d;
  end

  // Pins are registered from the next-state decode so they align with the state register.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      Ready_o <= 1'b1;
      Done_o  <= 1'b0;
      CS_o    <= 1'b1;
      SCK_o   <= 1'b0;
      MOSI_o  <= 1'b0;
      DC_o    <= 1'b0;
    end else begin
      Ready_o <= (state_d == ST_IDLE) || (state_d == ST_WAIT);
      Done_o  <= done_d;
      CS_o    <= (state_d == ST_IDLE) || (state_d == ST_GAP);
      SCK_o   <= (state_d == ST_SHIFT_HI);
      MOSI_o  <= ((state_d == ST_IDLE) || (state_d == ST_GAP)) ? 1'b0 : shreg_d[7];
      DC_o    <= dc_d;
    end
  end

endmodule
